// File: rtl/digit_shift_register_if.sv
// Control and display-data bundle for digit_shift_register.
// The scroll request exists only when DIGIT_SHIFT_AUTO_SCROLL_EN is defined.
interface digit_shift_register_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 4
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                    enable;
    logic [1:0]              mode;
    logic [WIDTH-1:0]        next_digit;
    logic [WIDTH*DIGITS-1:0] load_value;
`ifdef DIGIT_SHIFT_AUTO_SCROLL_EN
    logic                    scroll;
`endif
    logic [WIDTH*DIGITS-1:0] present;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    empty;
    logic                    overflow;

`ifdef DIGIT_SHIFT_AUTO_SCROLL_EN
    modport master (
        output enable, mode, next_digit, load_value, scroll,
        input  present, count, full, empty, overflow
    );
    modport slave (
        input  enable, mode, next_digit, load_value, scroll,
        output present, count, full, empty, overflow
    );
`else
    modport master (
        output enable, mode, next_digit, load_value,
        input  present, count, full, empty, overflow
    );
    modport slave (
        input  enable, mode, next_digit, load_value,
        output present, count, full, empty, overflow
    );
`endif
endinterface

// File: rtl/digit_shift_register.sv
// DIGITS x WIDTH display digit register: hold, load, shift-in, clear, occupancy tracking.
// Optional auto-rotate in hold mode when DIGIT_SHIFT_AUTO_SCROLL_EN is defined.
module digit_shift_register #(
    parameter int WIDTH      = 4,
    parameter int DIGITS     = 4,
    parameter int SCROLL_DIV = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    digit_shift_register_if.slave  bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int DW = WIDTH * DIGITS;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DIGITS);

    logic [DW-1:0] present_q, present_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

`ifdef DIGIT_SHIFT_AUTO_SCROLL_EN
    localparam int PW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCROLL_DIV - 1);
    logic [PW-1:0] prescaler_q, prescaler_d;
`endif

    // Next-state selection: enable gates everything, then mode decides.
    always_comb begin
        present_d  = present_q;
        count_d    = count_q;
        overflow_d = 1'b0;
`ifdef DIGIT_SHIFT_AUTO_SCROLL_EN
        prescaler_d = prescaler_q;
`endif
        if (bus.enable) begin
`ifdef DIGIT_SHIFT_AUTO_SCROLL_EN
            prescaler_d = {PW{1'b0}};
`endif
            case (bus.mode)
                2'b00: begin
`ifdef DIGIT_SHIFT_AUTO_SCROLL_EN
                    // Rotation happens on the edge the prescaler wraps.
                    if (bus.scroll) begin
                        if (prescaler_q == PRESC_LAST) begin
                            prescaler_d = {PW{1'b0}};
                            present_d   = {present_q[DW-WIDTH-1:0], present_q[DW-1 -: WIDTH]};
                        end else begin
                            prescaler_d = prescaler_q + {{(PW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        prescaler_d = {PW{1'b0}};
                    end
`else
                    present_d = present_q;
`endif
                end
                2'b01: begin
                    present_d = bus.load_value;
                    count_d   = COUNT_FULL;
                end
                2'b10: begin
                    present_d  = {present_q[DW-WIDTH-1:0], bus.next_digit};
                    overflow_d = (count_q == COUNT_FULL);
                    if (count_q == COUNT_FULL) begin
                        count_d = COUNT_FULL;
                    end else begin
                        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                2'b11: begin
                    present_d = {DW{1'b0}};
                    count_d   = {CW{1'b0}};
                end
                default: begin
                    present_d = present_q;
                end
            endcase
        end else begin
            present_d = present_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            present_q  <= {DW{1'b0}};
            count_q    <= {CW{1'b0}};
            overflow_q <= 1'b0;
`ifdef DIGIT_SHIFT_AUTO_SCROLL_EN
            prescaler_q <= {PW{1'b0}};
`endif
        end else begin
            present_q  <= present_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef DIGIT_SHIFT_AUTO_SCROLL_EN
            prescaler_q <= prescaler_d;
`endif
        end
    end

    assign bus.present  = present_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.full     = (count_q == COUNT_FULL);
    assign bus.empty    = (count_q == {CW{1'b0}});
endmodule
